// File: rtl/multicycle_controller.sv
// Multicycle MIPS-subset control unit: five-state FSM (IF/ID/EX/MEM/WB) whose
// datapath controls are decoded combinationally from State, OpCode and Funct.
module multicycle_controller #(
  parameter bit SUPPORT_JAL = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] OpCode,
  input  logic [5:0] Funct,
  output logic [2:0] State,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IorD,
  output logic       ExtOp,
  output logic       LuiOp,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUOp,
  output logic [1:0] PCSource
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_FN   = 3'd2;
  localparam logic [2:0] ALU_AND  = 3'd3;
  localparam logic [2:0] ALU_OR   = 3'd4;
  localparam logic [2:0] ALU_SLT  = 3'd5;
  localparam logic [2:0] ALU_SLTU = 3'd6;

  state_t state_q, state_d;

  // ---------------------------------------------------------------- decode
  logic is_rtype, r_legal, r_shift, r_exec;
  logic op_j, op_jal, fn_jr, fn_jalr, is_jump;
  logic is_ialu, is_lw, is_sw, is_beq, goes_ex;

  assign is_rtype = (OpCode == 6'h00);
  assign op_j     = (OpCode == 6'h02);
  assign op_jal   = (OpCode == 6'h03) && SUPPORT_JAL;
  assign fn_jr    = is_rtype && (Funct == 6'h08);
  assign fn_jalr  = is_rtype && (Funct == 6'h09) && SUPPORT_JAL;
  assign is_jump  = op_j | op_jal | fn_jr | fn_jalr;
  assign is_lw    = (OpCode == 6'h23);
  assign is_sw    = (OpCode == 6'h2b);
  assign is_beq   = (OpCode == 6'h04);
  assign r_shift  = (Funct == 6'h00) || (Funct == 6'h02) || (Funct == 6'h03);

  always_comb begin
    r_legal = 1'b0;
    case (Funct)
      6'h00, 6'h02, 6'h03, 6'h08,
      6'h20, 6'h21, 6'h22, 6'h23,
      6'h24, 6'h25, 6'h26, 6'h27,
      6'h2a, 6'h2b:                 r_legal = 1'b1;
      6'h09:                        r_legal = SUPPORT_JAL;
      default:                      r_legal = 1'b0;
    endcase
  end

  always_comb begin
    is_ialu = 1'b0;
    case (OpCode)
      6'h08, 6'h09, 6'h0a, 6'h0b,
      6'h0c, 6'h0d, 6'h0f:          is_ialu = 1'b1;
      default:                      is_ialu = 1'b0;
    endcase
  end

  // jr/jalr finish in ID, so only the remaining legal R-types reach EX
  assign r_exec  = is_rtype && r_legal && !fn_jr && !fn_jalr;
  assign goes_ex = r_exec | is_ialu | is_lw | is_sw | is_beq;

  // ---------------------------------------------------------------- state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IF;
    else        state_q <= state_d;
  end

  assign State = state_q;

  // ------------------------------------------------ next state and outputs
  logic       pcw_c, pcwc_c, irw_c, rw_c, mr_c, mw_c;
  logic       iord_c, ext_c, lui_c;
  logic [1:0] regdst_c, m2r_c, srca_c, srcb_c, pcsrc_c;
  logic [2:0] aluop_c;

  always_comb begin
    state_d  = S_IF;
    pcw_c    = 1'b0;
    pcwc_c   = 1'b0;
    irw_c    = 1'b0;
    rw_c     = 1'b0;
    mr_c     = 1'b0;
    mw_c     = 1'b0;
    iord_c   = 1'b0;
    ext_c    = 1'b0;
    lui_c    = 1'b0;
    regdst_c = 2'd0;
    m2r_c    = 2'd0;
    srca_c   = 2'd0;
    srcb_c   = 2'd0;
    pcsrc_c  = 2'd0;
    aluop_c  = ALU_ADD;

    case (state_q)
      S_IF: begin
        mr_c    = 1'b1;
        irw_c   = 1'b1;
        srcb_c  = 2'd1;
        pcw_c   = 1'b1;
        state_d = S_ID;
      end

      S_ID: begin
        // branch target is precomputed into ALUOut for every opcode
        srcb_c = 2'd3;
        ext_c  = 1'b1;
        if (is_jump) begin
          pcw_c   = 1'b1;
          pcsrc_c = (fn_jr || fn_jalr) ? 2'd3 : 2'd2;
          if (op_jal) begin
            rw_c     = 1'b1;
            regdst_c = 2'd2;
            m2r_c    = 2'd2;
          end
          if (fn_jalr) begin
            rw_c     = 1'b1;
            regdst_c = 2'd1;
            m2r_c    = 2'd2;
          end
          state_d = S_IF;
        end else if (goes_ex) begin
          state_d = S_EX;
        end else begin
          state_d = S_IF;
        end
      end

      S_EX: begin
        if (r_exec) begin
          srca_c  = r_shift ? 2'd2 : 2'd1;
          srcb_c  = 2'd0;
          aluop_c = ALU_FN;
          state_d = S_WB;
        end else if (is_ialu) begin
          srca_c = 2'd1;
          srcb_c = 2'd2;
          ext_c  = !((OpCode == 6'h0c) || (OpCode == 6'h0d));
          lui_c  = (OpCode == 6'h0f);
          case (OpCode)
            6'h0a:   aluop_c = ALU_SLT;
            6'h0b:   aluop_c = ALU_SLTU;
            6'h0c:   aluop_c = ALU_AND;
            6'h0d:   aluop_c = ALU_OR;
            default: aluop_c = ALU_ADD;
          endcase
          state_d = S_WB;
        end else if (is_lw || is_sw) begin
          srca_c  = 2'd1;
          srcb_c  = 2'd2;
          ext_c   = 1'b1;
          aluop_c = ALU_ADD;
          state_d = S_MEM;
        end else if (is_beq) begin
          srca_c  = 2'd1;
          srcb_c  = 2'd0;
          aluop_c = ALU_SUB;
          pcwc_c  = 1'b1;
          pcsrc_c = 2'd1;
          state_d = S_IF;
        end
      end

      S_MEM: begin
        if (is_lw) begin
          mr_c    = 1'b1;
          iord_c  = 1'b1;
          state_d = S_WB;
        end else if (is_sw) begin
          mw_c    = 1'b1;
          iord_c  = 1'b1;
        end
      end

      S_WB: begin
        if (r_exec) begin
          rw_c     = 1'b1;
          regdst_c = 2'd1;
        end else if (is_ialu) begin
          rw_c     = 1'b1;
        end else if (is_lw) begin
          rw_c     = 1'b1;
          m2r_c    = 2'd1;
        end
      end

      default: state_d = S_IF;
    endcase
  end

  // enables are held off for the whole time reset is asserted
  assign PCWrite     = pcw_c  & reset;
  assign PCWriteCond = pcwc_c & reset;
  assign IRWrite     = irw_c  & reset;
  assign RegWrite    = rw_c   & reset;
  assign MemRead     = mr_c   & reset;
  assign MemWrite    = mw_c   & reset;
  assign IorD        = iord_c;
  assign ExtOp       = ext_c;
  assign LuiOp       = lui_c;
  assign RegDst      = regdst_c;
  assign MemtoReg    = m2r_c;
  assign ALUSrcA     = srca_c;
  assign ALUSrcB     = srcb_c;
  assign ALUOp       = aluop_c;
  assign PCSource    = pcsrc_c;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench: a per-instruction trace model yields the expected
// control word for every cycle; a negedge process compares against the DUT.
module tb_multicycle_controller;

  localparam bit SUPPORT_JAL = 1'b1;

  logic       clk, reset;
  logic [5:0] OpCode, Funct;
  logic [2:0] State;
  logic       PCWrite, PCWriteCond, IRWrite, RegWrite, MemRead, MemWrite;
  logic       IorD, ExtOp, LuiOp;
  logic [1:0] RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSource;
  logic [2:0] ALUOp;

  multicycle_controller #(.SUPPORT_JAL(SUPPORT_JAL)) dut (
    .clk(clk), .reset(reset), .OpCode(OpCode), .Funct(Funct), .State(State),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD),
    .ExtOp(ExtOp), .LuiOp(LuiOp), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic pcw, pcwc, irw, rw, mr, mw, iord, ext, lui;
    logic [1:0] rd, m2r, sa, sb, ps;
    logic [2:0] alu;
  } rec_t;

  rec_t act;
  assign act = {State, PCWrite, PCWriteCond, IRWrite, RegWrite, MemRead, MemWrite,
                IorD, ExtOp, LuiOp, RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSource, ALUOp};

  rec_t exp_q[$];
  rec_t ce;
  int tests = 0;
  int fails = 0;

  // Expected trace of one instruction, one record per clock cycle.
  function automatic int build(input logic [5:0] op, input logic [5:0] fn, input bit push);
    rec_t q[$];
    rec_t r;
    bit rt, j, jal, jr, jalr, rleg, ialu, lw, sw, beq;
    rt   = (op == 6'h00);
    j    = (op == 6'h02);
    jal  = (op == 6'h03) && SUPPORT_JAL;
    jr   = rt && fn == 6'h08;
    jalr = rt && fn == 6'h09 && SUPPORT_JAL;
    rleg = rt && (fn inside {6'h00, 6'h02, 6'h03, [6'h20:6'h27], 6'h2a, 6'h2b});
    ialu = op inside {6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0f};
    lw   = (op == 6'h23);
    sw   = (op == 6'h2b);
    beq  = (op == 6'h04);

    r = '0; r.st = 3'd0; r.mr = 1; r.irw = 1; r.sb = 2'd1; r.pcw = 1;
    q.push_back(r);

    r = '0; r.st = 3'd1; r.sb = 2'd3; r.ext = 1;
    if (j || jal || jr || jalr) begin
      r.pcw = 1;
      r.ps  = (jr || jalr) ? 2'd3 : 2'd2;
      if (jal)  begin r.rw = 1; r.rd = 2'd2; r.m2r = 2'd2; end
      if (jalr) begin r.rw = 1; r.rd = 2'd1; r.m2r = 2'd2; end
    end
    q.push_back(r);

    if (!(j || jal || jr || jalr) && (rleg || ialu || lw || sw || beq)) begin
      r = '0; r.st = 3'd2;
      if (rleg) begin
        r.sa = (fn inside {6'h00, 6'h02, 6'h03}) ? 2'd2 : 2'd1;
        r.alu = 3'd2;
        q.push_back(r);
        r = '0; r.st = 3'd4; r.rw = 1; r.rd = 2'd1;
        q.push_back(r);
      end else if (ialu) begin
        r.sa = 2'd1; r.sb = 2'd2;
        r.ext = !(op inside {6'h0c, 6'h0d});
        r.lui = (op == 6'h0f);
        r.alu = (op == 6'h0a) ? 3'd5 : (op == 6'h0b) ? 3'd6 :
                (op == 6'h0c) ? 3'd3 : (op == 6'h0d) ? 3'd4 : 3'd0;
        q.push_back(r);
        r = '0; r.st = 3'd4; r.rw = 1;
        q.push_back(r);
      end else if (lw || sw) begin
        r.sa = 2'd1; r.sb = 2'd2; r.ext = 1;
        q.push_back(r);
        r = '0; r.st = 3'd3; r.iord = 1; r.mr = lw; r.mw = sw;
        q.push_back(r);
        if (lw) begin
          r = '0; r.st = 3'd4; r.rw = 1; r.m2r = 2'd1;
          q.push_back(r);
        end
      end else begin
        r.sa = 2'd1; r.alu = 3'd1; r.pcwc = 1; r.ps = 2'd1;
        q.push_back(r);
      end
    end
    if (push) foreach (q[i]) exp_q.push_back(q[i]);
    return q.size();
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      ce = exp_q.pop_front();
      tests++;
      if (act !== ce) begin
        fails++;
        $display("FAIL trace op=%h fn=%h state=%0d got=%h expected=%h",
                 OpCode, Funct, ce.st, act, ce);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] expv);
    tests++;
    if (got !== expv) begin
      fails++;
      $display("FAIL %s got=%0h expected=%0h", nm, got, expv);
    end
  endtask

  // called at posedge+1 with the DUT in IF
  task automatic run(input logic [5:0] op, input logic [5:0] fn);
    int n;
    OpCode = op; Funct = fn;
    n = build(op, fn, 1'b1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_idle(input string nm);
    chk({nm, "_state"}, State, 0);
    chk({nm, "_en"}, {PCWrite, PCWriteCond, IRWrite, RegWrite, MemWrite, MemRead}, 0);
  endtask

  // reset asserted mid-cycle during the k-th cycle (1-based) of an instruction
  task automatic abort_at(input logic [5:0] op, input logic [5:0] fn, input int k);
    int n;
    OpCode = op; Funct = fn;
    n = build(op, fn, 1'b1);
    if (k > n) k = n;
    repeat (n - k) void'(exp_q.pop_back());
    repeat (k - 1) @(posedge clk);
    @(negedge clk); #1;
    reset = 1'b0; #1;
    check_reset_idle("abort_async");
    @(posedge clk); #1;
    check_reset_idle("abort_held");
    reset = 1'b1; #1;
    chk("release_if", {PCWrite, MemRead, IRWrite}, 3'b111);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout tests=%0d", tests);
    $fatal(1, "timeout");
  end

  logic [5:0] dir_op [18] = '{6'h23, 6'h00, 6'h00, 6'h04, 6'h02, 6'h03, 6'h3f, 6'h00, 6'h00,
                               6'h2b, 6'h08, 6'h0c, 6'h0d, 6'h0f, 6'h0a, 6'h0b, 6'h00, 6'h00};
  logic [5:0] dir_fn [18] = '{6'h00, 6'h00, 6'h20, 6'h00, 6'h00, 6'h00, 6'h00, 6'h08, 6'h09,
                               6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h01, 6'h2a};
  logic [5:0] legal_ops [13] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h08, 6'h09, 6'h0a,
                                  6'h0b, 6'h0c, 6'h0d, 6'h0f, 6'h23, 6'h2b};

  initial begin
    logic [5:0] op, fn;
    reset = 1'b0; OpCode = 6'h00; Funct = 6'h00;

    // literal pins on the model's latencies
    chk("lat_lw",   build(6'h23, 6'h00, 0), 5);
    chk("lat_sw",   build(6'h2b, 6'h00, 0), 4);
    chk("lat_beq",  build(6'h04, 6'h00, 0), 3);
    chk("lat_add",  build(6'h00, 6'h20, 0), 4);
    chk("lat_addi", build(6'h08, 6'h00, 0), 4);
    chk("lat_j",    build(6'h02, 6'h00, 0), 2);
    chk("lat_jalr", build(6'h00, 6'h09, 0), 2);
    chk("lat_ill",  build(6'h3f, 6'h00, 0), 2);

    repeat (2) @(posedge clk); #1;
    check_reset_idle("reset");
    reset = 1'b1; #1;
    chk("first_if", {State, PCWrite, MemRead, IRWrite}, {3'd0, 3'b111});

    foreach (dir_op[i]) run(dir_op[i], dir_fn[i]);

    // reset during EX of lw, then a few random aborts
    abort_at(6'h23, 6'h00, 3);
    run(6'h23, 6'h00);
    for (int a = 0; a < 6; a++) begin
      abort_at(legal_ops[$urandom_range(12)], 6'h20, $urandom_range(5, 1));
      run(6'h02, 6'h00);
    end

    for (int t = 0; t < 300; t++) begin
      op = ($urandom_range(9) < 7) ? legal_ops[$urandom_range(12)] : 6'($urandom);
      fn = ($urandom_range(1) == 0) ? 6'($urandom_range(6'h2b, 6'h20)) : 6'($urandom);
      run(op, fn);
    end

    @(negedge clk); #1;
    chk("end_in_if", State, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter SUPPORT_JAL, default 1: 1 enables jal/jalr decode; 0 treats them as illegal.
REQ-002 clk  input  1  single system clock, rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 OpCode  input  6  instruction[31:26] from instruction register.
REQ-005 Funct  input  6  instruction[5:0] from instruction register.
REQ-006 State  output  3  current state: IF=0, ID=1, EX=2, MEM=3, WB=4.
REQ-007 PCWrite, PCWriteCond, IRWrite, RegWrite, MemRead, MemWrite  output  1 each  PC, IR, register-file and memory enables.
REQ-008 IorD  output  1  memory address select: 0=PC, 1=ALUOut.
REQ-009 ExtOp, LuiOp  output  1 each  1=sign-extend imm16; 1=imm16<<16.
REQ-010 RegDst  output  2  destination register: 0=rt, 1=rd, 2=$ra.
REQ-011 MemtoReg  output  2  write-back data: 0=ALUOut, 1=memory data register, 2=PC.
REQ-012 ALUSrcA  output  2  ALU A operand: 0=PC, 1=rs, 2=shamt.
REQ-013 ALUSrcB  output  2  ALU B operand: 0=rt, 1=const 4, 2=ext imm, 3=ext imm<<2.
REQ-014 ALUOp  output  3  ALU operation: 0=add, 1=sub, 2=by Funct, 3=and, 4=or, 5=slt, 6=sltu.
REQ-015 PCSource  output  2  next-PC source: 0=ALU result, 1=ALUOut, 2={PC[31:28],IR[25:0],2'b00}, 3=rs.

Function
REQ-016 State register SHALL update on rising clk; outputs SHALL be combinational from State, OpCode and Funct; every output not listed for a state SHALL be 0.
REQ-017 IF: MemRead=1, IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=1, ALUOp=0, PCSource=0, PCWrite=1; next state ID.
REQ-018 ID: ALUSrcA=0, ALUSrcB=3, ExtOp=1, ALUOp=0 (branch target into ALUOut).
REQ-019 ID, j (0x02): PCWrite=1, PCSource=2; next state IF.
REQ-020 ID, jal (0x03): j outputs plus RegWrite=1, RegDst=2, MemtoReg=2; next state IF.
REQ-021 ID, jr (OpCode 0, Funct 0x08): PCWrite=1, PCSource=3; jalr (Funct 0x09) adds RegWrite=1, RegDst=1, MemtoReg=2; next state IF.
REQ-022 ID, illegal OpCode, or unsupported R-type Funct: no writes; next state IF (executes as nop).
REQ-023 ID, all other legal opcodes: next state EX.
REQ-024 Legal R-type Funct set: 0x00, 0x02, 0x03, 0x08, 0x09, 0x20-0x27, 0x2a, 0x2b.
REQ-025 EX, R-type: ALUSrcA=2 if Funct is 0x00/0x02/0x03, else 1; ALUSrcB=0; ALUOp=2; next state WB.
REQ-026 EX, I-arith (0x08, 0x09, 0x0a, 0x0b, 0x0c, 0x0d, 0x0f): ALUSrcA=1, ALUSrcB=2; ExtOp=0 for 0x0c/0x0d, else 1; LuiOp=1 for 0x0f; ALUOp: add for 0x08/0x09/0x0f, slt 0x0a, sltu 0x0b, and 0x0c, or 0x0d; next state WB.
REQ-027 EX, lw (0x23) and sw (0x2b): ALUSrcA=1, ALUSrcB=2, ExtOp=1, ALUOp=0; next state MEM.
REQ-028 EX, beq (0x04): ALUSrcA=1, ALUSrcB=0, ALUOp=1, PCWriteCond=1, PCSource=1; next state IF.
REQ-029 MEM, lw: MemRead=1, IorD=1; next state WB.
REQ-030 MEM, sw: MemWrite=1, IorD=1; next state IF.
REQ-031 WB: RegWrite=1; R-type RegDst=1, MemtoReg=0; I-arith RegDst=0, MemtoReg=0; lw RegDst=0, MemtoReg=1; next state IF.
REQ-032 Latency in cycles: j/jal/jr/jalr/illegal 2; beq 3; R-type, I-arith and sw 4; lw 5.
REQ-033 Unused State encodings 5-7 SHALL drive all outputs 0 and return to IF on the next edge.
REQ-034 MemRead and MemWrite SHALL never be 1 in the same cycle; IRWrite SHALL be 1 only in IF.

Reset
REQ-035 While reset=0, State SHALL be IF asynchronously, and PCWrite, PCWriteCond, IRWrite, RegWrite and MemWrite SHALL be forced to 0.
REQ-036 Assertion of reset in any state, mid-instruction, SHALL abort that instruction with no further writes.
REQ-037 The first rising clk after reset deasserts SHALL be the IF cycle.

Verification
REQ-038 Reset: pull reset low during EX of lw -> State=0 and all enables 0 without a clock edge. Release reset -> next cycle PCWrite=1, MemRead=1, IRWrite=1.
REQ-039 lw: OpCode=0x23 -> States 0,1,2,3,4,0. MEM: MemRead=1, IorD=1. WB: RegWrite=1, MemtoReg=1, RegDst=0.
REQ-040 R-type: Funct=0x00 -> EX ALUSrcA=2. Funct=0x20 -> EX ALUSrcA=1. Both -> WB RegDst=1, RegWrite=1, 4 cycles.
REQ-041 beq: OpCode=0x04 -> States 0,1,2,0. EX: PCWriteCond=1, PCSource=1, ALUOp=1, PCWrite=0.
REQ-042 Jumps: OpCode=0x02 -> ID PCWrite=1, PCSource=2, 2 cycles. OpCode=0x03 -> additionally RegWrite=1, RegDst=2, MemtoReg=2.
REQ-043 Illegal: OpCode=0x3f -> States 0,1,0, with no RegWrite, MemWrite or PCWrite in ID.
